// File: rtl/ram_controller.sv
// ---------------------------------------------------------------------------
// ram_controller
//   Circular sample buffer with a read-out state machine. In IDLE, samples
//   are written at wr_ptr on every `we` strobe. A `rqst_data` pulse reads the
//   newest N = min(num_samples, DEPTH) samples, oldest first. Each sample is
//   handed to the Tx protocol with a tx_rdy/tx_ack handshake. tx_eof marks
//   the last sample of the transfer.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   we, data_in  : sample write strobe and data (only honoured in IDLE)
//   num_samples  : number of samples to read out on a request
//   rqst_data    : single-cycle read-out request (only honoured in IDLE)
//   tx_data      : sample presented to the Tx protocol
//   tx_rdy       : tx_data valid, held until tx_ack
//   tx_eof       : tx_data is the last sample of the transfer
//   tx_ack       : Tx protocol consumed tx_data
// ---------------------------------------------------------------------------
module ram_controller #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int BITS_ADC       = 8,
  parameter int REG_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [BITS_ADC-1:0]       data_in,
  input  logic [REG_DATA_WIDTH-1:0] num_samples,
  input  logic                      rqst_data,
  output logic [BITS_ADC-1:0]       tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack
);

  localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;
  localparam int REM_W = RAM_ADDR_WIDTH + 1;
  // Wide enough to compare num_samples against DEPTH without truncating either.
  localparam int CW    = (REG_DATA_WIDTH > REM_W) ? REG_DATA_WIDTH : REM_W;

  localparam logic [CW-1:0]             DEPTH_C = CW'(DEPTH);
  localparam logic [REM_W-1:0]          DEPTH_N = REM_W'(DEPTH);
  localparam logic [REM_W-1:0]          REM_ONE = REM_W'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] PTR_ONE = RAM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND
  } state_t;

  state_t                      state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [REM_W-1:0]            remaining_q, remaining_d;
  logic [BITS_ADC-1:0]         tx_data_q, tx_data_d;
  logic                        tx_rdy_q, tx_rdy_d;
  logic                        tx_eof_q, tx_eof_d;

  logic [BITS_ADC-1:0]         mem_q [DEPTH];
  logic [BITS_ADC-1:0]         rd_word_q;

  logic                        mem_we;
  logic                        rd_en;
  logic [RAM_ADDR_WIDTH-1:0]   wr_ptr_post;
  logic [CW-1:0]               num_ext;
  logic [REM_W-1:0]            n_req;

  assign num_ext = CW'(num_samples);

  // Clamp the requested count to the buffer depth.
  always_comb begin
    n_req = num_ext[REM_W-1:0];
    if (num_ext > DEPTH_C) begin
      n_req = DEPTH_N;
    end
  end

  // Buffer storage and its registered read port; contents are never reset.
  // Writes are suppressed while reset is held so a stray `we` cannot land.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
    if (rd_en) begin
      rd_word_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      tx_data_q   <= '0;
      tx_rdy_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      tx_data_q   <= tx_data_d;
      tx_rdy_q    <= tx_rdy_d;
      tx_eof_q    <= tx_eof_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    tx_data_d   = tx_data_q;
    tx_rdy_d    = tx_rdy_q;
    tx_eof_d    = tx_eof_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    wr_ptr_post = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (we) begin
          mem_we      = 1'b1;
          wr_ptr_post = wr_ptr_q + PTR_ONE;
        end
        wr_ptr_d = wr_ptr_post;
        // Start from the post-write pointer so a same-cycle write is the
        // newest sample of the transfer. N == DEPTH wraps to rd_ptr == wr_ptr.
        if (rqst_data && (n_req != '0)) begin
          rd_ptr_d    = wr_ptr_post - n_req[RAM_ADDR_WIDTH-1:0];
          remaining_d = n_req;
          state_d     = READ;
        end
      end

      READ: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        // First SEND cycle has tx_rdy low: present the word just read.
        // Acks are only honoured once tx_rdy is high.
        if (!tx_rdy_q) begin
          tx_data_d = rd_word_q;
          tx_rdy_d  = 1'b1;
          tx_eof_d  = (remaining_q == REM_ONE);
        end else if (tx_ack) begin
          tx_rdy_d    = 1'b0;
          tx_eof_d    = 1'b0;
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          remaining_d = remaining_q - REM_ONE;
          state_d     = (remaining_q == REM_ONE) ? IDLE : READ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data = tx_data_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_eof  = tx_eof_q;

endmodule

// File: doc/ram_controller.md
RAM_CONTROLLER -- requirements
Module: ram_controller

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_WIDTH, default 8: buffer depth is DEPTH = 2^RAM_ADDR_WIDTH samples.
REQ-002 The block SHALL have parameter BITS_ADC, default 8: sample width.
REQ-003 The block SHALL have parameter REG_DATA_WIDTH, default 16: width of num_samples.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports `clk` (input, 1 bit, clock) and `rst` (input, 1 bit, asynchronous active-high reset).
REQ-005 The block SHALL have port `we` (input, 1 bit): write strobe from the buffer controller.
REQ-006 The block SHALL have port `data_in` (input, BITS_ADC bits): sample written when `we` is high.
REQ-007 The block SHALL have port `num_samples` (input, REG_DATA_WIDTH bits): number of samples to read out, taken from the num_samples register.
REQ-008 The block SHALL have port `rqst_data` (input, 1 bit): single-cycle read-out request from the request handler.
REQ-009 The block SHALL have port `tx_data` (output, BITS_ADC bits): sample presented to the Tx protocol.
REQ-010 The block SHALL have port `tx_rdy` (output, 1 bit): tx_data valid.
REQ-011 The block SHALL have port `tx_eof` (output, 1 bit): current tx_data is the last sample of the transfer.
REQ-012 The block SHALL have port `tx_ack` (input, 1 bit): Tx protocol consumed tx_data.

Function
REQ-013 The block SHALL contain a DEPTH x BITS_ADC circular buffer, with synchronous read (1-cycle latency) and no reset of contents.
REQ-014 In IDLE with `we`=1, the block SHALL store data_in at wr_ptr and increment wr_ptr modulo DEPTH (wrapping from DEPTH-1 to 0).
REQ-015 The block SHALL ignore `we` while not in IDLE: no write occurs and wr_ptr holds.
REQ-016 When rqst_data=1 in IDLE, the block SHALL latch N = min(num_samples, DEPTH), set rd_ptr = (wr_ptr - N) mod DEPTH, load remaining = N, and go to READ.
REQ-017 When rqst_data=1 in IDLE and num_samples=0, the block SHALL stay in IDLE and never assert tx_rdy.
REQ-018 When rqst_data and we are both 1 in IDLE, the write SHALL occur first, and rd_ptr SHALL be computed from the post-write wr_ptr so that the newest sample is included.
REQ-019 The block SHALL ignore rqst_data outside IDLE.
REQ-020 The state machine SHALL have states IDLE, READ and SEND.
REQ-021 In READ (one cycle), the block SHALL issue a buffer read at rd_ptr and go to SEND.
REQ-022 On entering SEND, the block SHALL drive tx_data with the read word, set tx_rdy=1, and set tx_eof=1 iff remaining=1.
REQ-023 In SEND, tx_data, tx_rdy and tx_eof SHALL be held stable until tx_ack=1; there is no timeout.
REQ-024 On tx_ack=1 in SEND, the next cycle SHALL have tx_rdy=0 and tx_eof=0, rd_ptr+1 (mod DEPTH), and remaining-1.
REQ-025 After the ack in REQ-024, the block SHALL go to IDLE if remaining was 1, otherwise to READ.
REQ-026 tx_ack while tx_rdy=0 SHALL be ignored.
REQ-027 Timing: rqst_data sampled at edge t SHALL give tx_rdy=1 after edge t+2; an ack at edge k SHALL give the next tx_rdy=1 after edge k+2.
REQ-028 tx_eof SHALL be asserted exactly once per transfer, coincident with tx_rdy.
REQ-029 The pointers SHALL be RAM_ADDR_WIDTH bits with natural wrap-around, and remaining SHALL be RAM_ADDR_WIDTH+1 bits.

Reset
REQ-030 When rst=1, the block SHALL asynchronously force state=IDLE, wr_ptr=0, rd_ptr=0, remaining=0, tx_data=0, tx_rdy=0, tx_eof=0.
REQ-031 Reset during a transfer SHALL abort it with no further tx_rdy; buffer contents are not cleared.
REQ-032 After rst deasserts, the block SHALL accept we or rqst_data on the first clock edge.

Verification
REQ-033 The bench SHALL cover: write 0..9, num_samples=4, rqst with immediate ack -> tx_data 6,7,8,9, with tx_eof only on 9.
REQ-034 The bench SHALL cover: write 300 samples (value = i mod 256), num_samples=5 -> tx_data 39,40,41,42,43 (wr_ptr=44).
REQ-035 The bench SHALL cover: buffer full, num_samples=1000 -> exactly 256 tx_rdy handshakes, tx_eof on the 256th.
REQ-036 The bench SHALL cover: tx_ack held low 5 cycles mid-transfer -> tx_rdy, tx_data and tx_eof stable; we pulses during the transfer leave wr_ptr unchanged.
REQ-037 The bench SHALL cover: num_samples=0 with rqst -> tx_rdy never asserts and the block stays in IDLE.
REQ-038 The bench SHALL cover: rst pulse on the 2nd sample of a 4-sample transfer -> tx_rdy=0 immediately, no further samples, and a new rqst after writes works normally.
